// File: rtl/issue_queue_int.sv
// rtl/issue_queue_int.sv - integer reservation station: compacting queue with CDB wakeup and oldest-ready issue
module issue_queue_int #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dispatch_en,
    input  logic [3:0]                 dispatch_opcode,
    input  logic [31:0]                dispatch_rsdata,
    input  logic [TAG_W-1:0]           dispatch_rstag,
    input  logic                       dispatch_rs_valid,
    input  logic [31:0]                dispatch_rtdata,
    input  logic [TAG_W-1:0]           dispatch_rttag,
    input  logic                       dispatch_rt_valid,
    input  logic [TAG_W-1:0]           dispatch_rdtag,
    output logic                       issueque_full,
    output logic [$clog2(DEPTH):0]     issueque_count,
    input  logic                       flush,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tagout,
    input  logic [31:0]                cdb_out,
    output logic                       issueint_ready,
    output logic [3:0]                 issueint_opcode,
    output logic [31:0]                issueint_rsdata,
    output logic [31:0]                issueint_rtdata,
    output logic [TAG_W-1:0]           issueint_rdtag,
    input  logic                       issueint_equeueint_done
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    typedef struct packed {
        logic             valid;
        logic [3:0]       opcode;
        logic [31:0]      rsdata;
        logic [TAG_W-1:0] rstag;
        logic             rs_rdy;
        logic [31:0]      rtdata;
        logic [TAG_W-1:0] rttag;
        logic             rt_rdy;
        logic [TAG_W-1:0] rdtag;
    } entry_t;

    entry_t          entry_q [DEPTH];
    entry_t          entry_d [DEPTH];
    entry_t          upper   [DEPTH];
    entry_t          new_e;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic [CW-1:0]   wr_idx;
    logic [IW-1:0]   sel_idx;
    logic            sel_found;
    logic            issue_fire;
    logic            disp_accept;

    // Capture a matching broadcast into any operand still waiting on it.
    function automatic entry_t snoop(input entry_t e, input logic v,
                                     input logic [TAG_W-1:0] tag, input logic [31:0] data);
        entry_t r;
        r = e;
        if (v && e.valid && !e.rs_rdy && (e.rstag == tag)) begin
            r.rsdata = data;
            r.rs_rdy = 1'b1;
        end
        if (v && e.valid && !e.rt_rdy && (e.rttag == tag)) begin
            r.rtdata = data;
            r.rt_rdy = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (entry_q[i].valid && entry_q[i].rs_rdy && entry_q[i].rt_rdy) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    assign issueque_full  = (count_q == CW'(DEPTH));
    assign issueque_count = count_q;
    assign issueint_ready = sel_found;
    assign issue_fire     = sel_found & issueint_equeueint_done;
    assign disp_accept    = dispatch_en & ~issueque_full;
    assign wr_idx         = count_q - CW'(issue_fire);

    always_comb begin
        issueint_opcode = '0;
        issueint_rsdata = '0;
        issueint_rtdata = '0;
        issueint_rdtag  = '0;
        if (sel_found) begin
            issueint_opcode = entry_q[sel_idx].opcode;
            issueint_rsdata = entry_q[sel_idx].rsdata;
            issueint_rtdata = entry_q[sel_idx].rtdata;
            issueint_rdtag  = entry_q[sel_idx].rdtag;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            upper[i] = entry_q[i + 1];
        end
        upper[DEPTH-1] = '0;
    end

    // Dispatched entry goes through the same snoop, so a racing broadcast is not lost.
    always_comb begin
        new_e        = '0;
        new_e.valid  = 1'b1;
        new_e.opcode = dispatch_opcode;
        new_e.rsdata = dispatch_rsdata;
        new_e.rstag  = dispatch_rstag;
        new_e.rs_rdy = dispatch_rs_valid;
        new_e.rtdata = dispatch_rtdata;
        new_e.rttag  = dispatch_rttag;
        new_e.rt_rdy = dispatch_rt_valid;
        new_e.rdtag  = dispatch_rdtag;
        new_e        = snoop(new_e, cdb_valid, cdb_tagout, cdb_out);
    end

    // Slots at or above the issued one take their upper neighbour, then snoop in the new slot.
    always_comb begin
        count_d = wr_idx + CW'(disp_accept);
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = (issue_fire && (IW'(i) >= sel_idx)) ? upper[i] : entry_q[i];
            entry_d[i] = snoop(entry_d[i], cdb_valid, cdb_tagout, cdb_out);
            if (disp_accept && (CW'(i) == wr_idx)) begin
                entry_d[i] = new_e;
            end
            if (flush) begin
                entry_d[i].valid = 1'b0;
            end
        end
        if (flush) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_issue_queue_int.sv
// tb/tb_issue_queue_int.sv - directed scoreboard bench for issue_queue_int
module tb_issue_queue_int;

    logic        clk = 1'b0;
    logic        reset;
    logic        dispatch_en;
    logic [3:0]  dispatch_opcode;
    logic [31:0] dispatch_rsdata;
    logic [5:0]  dispatch_rstag;
    logic        dispatch_rs_valid;
    logic [31:0] dispatch_rtdata;
    logic [5:0]  dispatch_rttag;
    logic        dispatch_rt_valid;
    logic [5:0]  dispatch_rdtag;
    logic        issueque_full;
    logic [3:0]  issueque_count;
    logic        flush;
    logic        cdb_valid;
    logic [5:0]  cdb_tagout;
    logic [31:0] cdb_out;
    logic        issueint_ready;
    logic [3:0]  issueint_opcode;
    logic [31:0] issueint_rsdata;
    logic [31:0] issueint_rtdata;
    logic [5:0]  issueint_rdtag;
    logic        issueint_equeueint_done;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [5:0]  rd;
    } exp_t;

    exp_t sb[$];
    int vectors     = 0;
    int miscompares = 0;

    issue_queue_int #(.DEPTH(8), .TAG_W(6)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .dispatch_en             (dispatch_en),
        .dispatch_opcode         (dispatch_opcode),
        .dispatch_rsdata         (dispatch_rsdata),
        .dispatch_rstag          (dispatch_rstag),
        .dispatch_rs_valid       (dispatch_rs_valid),
        .dispatch_rtdata         (dispatch_rtdata),
        .dispatch_rttag          (dispatch_rttag),
        .dispatch_rt_valid       (dispatch_rt_valid),
        .dispatch_rdtag          (dispatch_rdtag),
        .issueque_full           (issueque_full),
        .issueque_count          (issueque_count),
        .flush                   (flush),
        .cdb_valid               (cdb_valid),
        .cdb_tagout              (cdb_tagout),
        .cdb_out                 (cdb_out),
        .issueint_ready          (issueint_ready),
        .issueint_opcode         (issueint_opcode),
        .issueint_rsdata         (issueint_rsdata),
        .issueint_rtdata         (issueint_rtdata),
        .issueint_rdtag          (issueint_rdtag),
        .issueint_equeueint_done (issueint_equeueint_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [5:0] rd);
        exp_t e;
        e.op = op; e.rs = rs; e.rt = rt; e.rd = rd;
        sb.push_back(e);
    endtask

    task automatic disp(input logic [3:0] op, input logic [31:0] rs, input logic [5:0] rstag,
                        input logic rsv, input logic [31:0] rt, input logic [5:0] rttag,
                        input logic rtv, input logic [5:0] rd);
        dispatch_en       = 1'b1;
        dispatch_opcode   = op;
        dispatch_rsdata   = rs;
        dispatch_rstag    = rstag;
        dispatch_rs_valid = rsv;
        dispatch_rtdata   = rt;
        dispatch_rttag    = rttag;
        dispatch_rt_valid = rtv;
        dispatch_rdtag    = rd;
        tick();
        dispatch_en       = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        int   n = 0;
        while (!issueint_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, 64'(issueint_ready), 64'd1);
        chk({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_opcode"}, 64'(issueint_opcode), 64'(e.op));
            chk({tag, "_rsdata"}, 64'(issueint_rsdata), 64'(e.rs));
            chk({tag, "_rtdata"}, 64'(issueint_rtdata), 64'(e.rt));
            chk({tag, "_rdtag"},  64'(issueint_rdtag),  64'(e.rd));
        end
        issueint_equeueint_done = 1'b1;
        tick();
        issueint_equeueint_done = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; dispatch_en = 1'b0;
        dispatch_opcode = '0; dispatch_rsdata = '0; dispatch_rstag = '0; dispatch_rs_valid = 1'b0;
        dispatch_rtdata = '0; dispatch_rttag = '0; dispatch_rt_valid = 1'b0; dispatch_rdtag = '0;
        cdb_valid = 1'b0; cdb_tagout = '0; cdb_out = '0; issueint_equeueint_done = 1'b0;
        tick();
        tick();
        chk("rst_ready",  64'(issueint_ready),  64'd0);
        chk("rst_full",   64'(issueque_full),   64'd0);
        chk("rst_count",  64'(issueque_count),  64'd0);
        chk("rst_opcode", 64'(issueint_opcode), 64'd0);
        chk("rst_rsdata", 64'(issueint_rsdata), 64'd0);
        chk("rst_rtdata", 64'(issueint_rtdata), 64'd0);
        chk("rst_rdtag",  64'(issueint_rdtag),  64'd0);
        reset = 1'b0;
        tick();

        // basic dispatch then issue
        disp(4'h2, 32'd5, 6'h00, 1'b1, 32'd7, 6'h00, 1'b1, 6'h0A);
        push(4'h2, 32'd5, 32'd7, 6'h0A);
        chk("t1_count", 64'(issueque_count), 64'd1);
        chk("t1_ready_next", 64'(issueint_ready), 64'd1);
        pop_check("t1");
        chk("t1_count_after", 64'(issueque_count), 64'd0);
        chk("t1_ready_after", 64'(issueint_ready), 64'd0);

        // CDB wakeup of rs
        disp(4'h3, 32'hDEAD, 6'h11, 1'b0, 32'd3, 6'h00, 1'b1, 6'h0B);
        chk("t2_wait0", 64'(issueint_ready), 64'd0);
        tick();
        chk("t2_wait1", 64'(issueint_ready), 64'd0);
        cdb_valid = 1'b1; cdb_tagout = 6'h11; cdb_out = 32'h1234;
        push(4'h3, 32'h1234, 32'd3, 6'h0B);
        tick();
        cdb_valid = 1'b0;
        chk("t2_ready_next", 64'(issueint_ready), 64'd1);
        pop_check("t2");

        // age order with a pending older entry
        disp(4'h1, 32'h0, 6'h05, 1'b0, 32'd1, 6'h00, 1'b1, 6'h21);
        disp(4'h4, 32'h10, 6'h00, 1'b1, 32'h20, 6'h00, 1'b1, 6'h22);
        push(4'h4, 32'h10, 32'h20, 6'h22);
        disp(4'h5, 32'h30, 6'h00, 1'b1, 32'h40, 6'h00, 1'b1, 6'h23);
        push(4'h5, 32'h30, 32'h40, 6'h23);
        pop_check("t3_b");
        pop_check("t3_c");
        chk("t3_count_a", 64'(issueque_count), 64'd1);
        chk("t3_a_blocked", 64'(issueint_ready), 64'd0);
        cdb_valid = 1'b1; cdb_tagout = 6'h05; cdb_out = 32'h55;
        push(4'h1, 32'h55, 32'd1, 6'h21);
        tick();
        cdb_valid = 1'b0;
        pop_check("t3_a");
        chk("t3_count_end", 64'(issueque_count), 64'd0);

        // fill to full, ignored dispatch, drain one
        for (int i = 0; i < 8; i++) begin
            disp(4'(8 + i), 32'h0, 6'(8'h30 + i), 1'b0, 32'(i), 6'h00, 1'b1, 6'(i));
        end
        chk("t4_full", 64'(issueque_full), 64'd1);
        chk("t4_count8", 64'(issueque_count), 64'd8);
        chk("t4_none_ready", 64'(issueint_ready), 64'd0);
        disp(4'hF, 32'h1, 6'h00, 1'b1, 32'h2, 6'h00, 1'b1, 6'h3F);
        chk("t4_ignored_count", 64'(issueque_count), 64'd8);
        chk("t4_ignored_ready", 64'(issueint_ready), 64'd0);
        cdb_valid = 1'b1; cdb_tagout = 6'h33; cdb_out = 32'h333;
        push(4'hB, 32'h333, 32'd3, 6'd3);
        tick();
        cdb_valid = 1'b0;
        chk("t4_still_full", 64'(issueque_full), 64'd1);
        pop_check("t4_wake");
        chk("t4_full_drop", 64'(issueque_full), 64'd0);
        chk("t4_count7", 64'(issueque_count), 64'd7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_flush_count", 64'(issueque_count), 64'd0);

        // dispatch/CDB race bypass
        cdb_valid = 1'b1; cdb_tagout = 6'h22; cdb_out = 32'hBEEF;
        disp(4'h6, 32'h0, 6'h22, 1'b0, 32'd9, 6'h00, 1'b1, 6'h2A);
        cdb_valid = 1'b0;
        push(4'h6, 32'hBEEF, 32'd9, 6'h2A);
        chk("t5_ready_next", 64'(issueint_ready), 64'd1);
        pop_check("t5");

        // wakeup captured into a shifting entry, both operands on one broadcast
        disp(4'h7, 32'h70, 6'h00, 1'b1, 32'h71, 6'h00, 1'b1, 6'h30);
        push(4'h7, 32'h70, 32'h71, 6'h30);
        disp(4'h8, 32'h0, 6'h07, 1'b0, 32'h0, 6'h07, 1'b0, 6'h31);
        cdb_valid = 1'b1; cdb_tagout = 6'h07; cdb_out = 32'h77;
        pop_check("t5_x");
        cdb_valid = 1'b0;
        push(4'h8, 32'h77, 32'h77, 6'h31);
        chk("t5_y_ready", 64'(issueint_ready), 64'd1);
        pop_check("t5_y");

        // flush beats dispatch and done
        disp(4'h9, 32'h90, 6'h00, 1'b1, 32'h91, 6'h00, 1'b1, 6'h32);
        for (int i = 0; i < 4; i++) begin
            disp(4'hA, 32'h0, 6'(8'h20 + i), 1'b0, 32'h0, 6'h00, 1'b1, 6'(8'h33 + i));
        end
        chk("t6_count5", 64'(issueque_count), 64'd5);
        chk("t6_ready_pre", 64'(issueint_ready), 64'd1);
        flush = 1'b1; issueint_equeueint_done = 1'b1;
        disp(4'hC, 32'h1, 6'h00, 1'b1, 32'h2, 6'h00, 1'b1, 6'h3E);
        flush = 1'b0; issueint_equeueint_done = 1'b0;
        chk("t6_count0", 64'(issueque_count), 64'd0);
        chk("t6_ready0", 64'(issueint_ready), 64'd0);
        tick();
        chk("t6_dropped", 64'(issueint_ready), 64'd0);

        // reset mid-operation
        disp(4'hD, 32'hD0, 6'h00, 1'b1, 32'hD1, 6'h00, 1'b1, 6'h3D);
        chk("t7_pre_count", 64'(issueque_count), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t7_count", 64'(issueque_count), 64'd0);
        chk("t7_ready", 64'(issueint_ready), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
